spi_apb_xfer_sequencer: RTL and testbench

APB master that shares the SPI APB slave register block (CR1@0, CR2@1, BR@2, SR@3, DR@5) among NREQ byte requesters.
- Round-robin arbitration picks one requester.
- Each transfer is sequenced as: DR write, SR poll until done, DR read.
- The received byte returns to the winner with a done/error pulse.
- Sits between client logic and the SPI controller APB port; it is the only master on that port.

---
 rtl/spi_pkg.sv | 39 +++
 rtl/spi_apb_xfer_sequencer_if.sv | 32 +++
 rtl/spi_rr_arbiter.sv | 43 ++++
 rtl/spi_apb_xfer_sequencer.sv | 258 +++++++++++++++++++++++++
 tb/tb_spi_apb_xfer_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI APB transfer sequencer: register map,
// SR bit positions, FSM state encoding and the APB request payload.
// Optional feature macro: SPI_SEQ_INIT_EN (adds INIT_S/INIT_A states).
package spi_pkg;

    localparam logic [2:0] ADDR_CR1 = 3'd0;
    localparam logic [2:0] ADDR_CR2 = 3'd1;
    localparam logic [2:0] ADDR_BR  = 3'd2;
    localparam logic [2:0] ADDR_SR  = 3'd3;
    localparam logic [2:0] ADDR_DR  = 3'd5;

    localparam int unsigned SR_SPIF  = 7;
    localparam int unsigned SR_SPTEF = 5;
    localparam int unsigned SR_MODF  = 4;

    localparam int unsigned STATE_W = 4;

    localparam logic [3:0] ARB    = 4'd0;
    localparam logic [3:0] WR_S   = 4'd1;
    localparam logic [3:0] WR_A   = 4'd2;
    localparam logic [3:0] PL_S   = 4'd3;
    localparam logic [3:0] PL_A   = 4'd4;
    localparam logic [3:0] RD_S   = 4'd5;
    localparam logic [3:0] RD_A   = 4'd6;
    localparam logic [3:0] FIN    = 4'd7;
`ifdef SPI_SEQ_INIT_EN
    localparam logic [3:0] INIT_S = 4'd8;
    localparam logic [3:0] INIT_A = 4'd9;
`endif

    typedef struct packed {
        logic       sel;
        logic       enable;
        logic       write;
        logic [2:0] addr;
        logic [7:0] wdata;
    } apb_req_t;

endpackage

// File: rtl/spi_apb_xfer_sequencer_if.sv
// Client request/response and APB master signals of the transfer sequencer.
interface spi_apb_xfer_sequencer_if #(
    parameter int unsigned NREQ = 2
);
    logic [NREQ-1:0]   req_i;
    logic [8*NREQ-1:0] wdata_i;
    logic [NREQ-1:0]   gnt_o;
    logic [NREQ-1:0]   done_o;
    logic [7:0]        rdata_o;
    logic              err_o;
    logic              busy_o;
    logic              PSEL_o;
    logic              PENABLE_o;
    logic              PWRITE_o;
    logic [2:0]        PADDR_o;
    logic [7:0]        PWDATA_o;
    logic [7:0]        PRDATA_i;
    logic              PREADY_i;
    logic              PSLVERR_i;

    modport master (
        input  req_i, wdata_i, PRDATA_i, PREADY_i, PSLVERR_i,
        output gnt_o, done_o, rdata_o, err_o, busy_o,
               PSEL_o, PENABLE_o, PWRITE_o, PADDR_o, PWDATA_o
    );

    modport slave (
        output req_i, wdata_i, PRDATA_i, PREADY_i, PSLVERR_i,
        input  gnt_o, done_o, rdata_o, err_o, busy_o,
               PSEL_o, PENABLE_o, PWRITE_o, PADDR_o, PWDATA_o
    );
endinterface

// File: rtl/spi_rr_arbiter.sv
// Round-robin arbiter: first set request at or after the pointer wins;
// the pointer moves past the winner only when the grant is accepted.
module spi_rr_arbiter #(
    parameter int unsigned NREQ = 2,
    localparam int unsigned IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            PCLK,
    input  logic            PRESET,
    input  logic [NREQ-1:0] req,
    input  logic            accept,
    output logic            valid_c,
    output logic [NREQ-1:0] gnt_c,
    output logic [IW-1:0]   idx_c
);

    logic [IW-1:0] ptr_q;
    int            k;

    // Scan downwards so the lowest offset from the pointer is the last write.
    always_comb begin
        valid_c = 1'b0;
        idx_c   = '0;
        k       = 0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            k = (int'(ptr_q) + i) % int'(NREQ);
            if (req[IW'(k)]) begin
                valid_c = 1'b1;
                idx_c   = IW'(k);
            end
        end
        gnt_c = valid_c ? (NREQ'(1) << idx_c) : '0;
    end

    // Pointer advances to winner+1 (mod NREQ) on an accepted grant.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ptr_q <= '0;
        end else if (accept) begin
            ptr_q <= (idx_c == IW'(NREQ - 1)) ? '0 : IW'(idx_c + 1'b1);
        end
    end

endmodule

// File: rtl/spi_apb_xfer_sequencer.sv
// APB master sharing the SPI register block among NREQ byte requesters:
// arbitrate, write DR, poll SR for completion, read DR, report to winner.
// Optional feature macro: SPI_SEQ_INIT_EN writes CR1/CR2/BR after reset.
module spi_apb_xfer_sequencer
    import spi_pkg::*;
#(
    parameter int unsigned NREQ      = 2,
    parameter logic [7:0]  POLL_MASK = 8'(1 << SR_SPIF),
    parameter int unsigned POLL_MAX  = 16,
    parameter int unsigned RETRY_MAX = 3
`ifdef SPI_SEQ_INIT_EN
    ,
    parameter logic [7:0]  CR1_INIT  = 8'h54,
    parameter logic [7:0]  CR2_INIT  = 8'h00,
    parameter logic [7:0]  BR_INIT   = 8'h00
`endif
) (
    input  logic PCLK,
    input  logic PRESET,
    spi_apb_xfer_sequencer_if.master bus
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned PW = $clog2(POLL_MAX + 1);
    localparam int unsigned RW = $clog2(RETRY_MAX + 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [7:0]         byte_q, byte_d;
    logic [RW-1:0]      retry_q, retry_d;
    logic [PW-1:0]      poll_q, poll_d;
    logic [7:0]         res_q, res_d;
    logic               res_err_q, res_err_d;
    apb_req_t           apb_q, apb_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [NREQ-1:0]    done_q, done_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               arb_accept_c;
    logic               arb_valid_c;
    logic [NREQ-1:0]    arb_gnt_c;
    logic [IW-1:0]      arb_idx_c;
`ifdef SPI_SEQ_INIT_EN
    logic [1:0]         init_cnt_q, init_cnt_d;
    logic               init_done_q, init_done_d;
    logic [7:0]         init_byte_c;
`endif

    spi_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .req     (bus.req_i),
        .accept  (arb_accept_c),
        .valid_c (arb_valid_c),
        .gnt_c   (arb_gnt_c),
        .idx_c   (arb_idx_c)
    );

    // State, datapath and registered outputs.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= ARB;
            idx_q       <= '0;
            byte_q      <= '0;
            retry_q     <= '0;
            poll_q      <= '0;
            res_q       <= '0;
            res_err_q   <= 1'b0;
            apb_q       <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SPI_SEQ_INIT_EN
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            byte_q      <= byte_d;
            retry_q     <= retry_d;
            poll_q      <= poll_d;
            res_q       <= res_d;
            res_err_q   <= res_err_d;
            apb_q       <= apb_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
`ifdef SPI_SEQ_INIT_EN
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
`endif
        end
    end

    // Next-state, transfer bookkeeping and pulse outputs.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        byte_d       = byte_q;
        retry_d      = retry_q;
        poll_d       = poll_q;
        res_d        = res_q;
        res_err_d    = res_err_q;
        gnt_d        = '0;
        done_d       = '0;
        rdata_d      = rdata_q;
        err_d        = err_q;
        arb_accept_c = 1'b0;
`ifdef SPI_SEQ_INIT_EN
        init_cnt_d   = init_cnt_q;
        init_done_d  = init_done_q;
`endif
        case (state_q)
            ARB: begin
`ifdef SPI_SEQ_INIT_EN
                if (!init_done_q) state_d = INIT_S;
                else
`endif
                if (arb_valid_c) begin
                    arb_accept_c = 1'b1;
                    idx_d        = arb_idx_c;
                    byte_d       = bus.wdata_i[{arb_idx_c, 3'b000} +: 8];
                    gnt_d        = arb_gnt_c;
                    res_d        = '0;
                    res_err_d    = 1'b0;
                    retry_d      = '0;
                    poll_d       = '0;
                    state_d      = WR_S;
                end
            end
            WR_S: state_d = WR_A;
            WR_A: begin
                if (bus.PREADY_i) begin
                    if (!bus.PSLVERR_i) begin
                        state_d = PL_S;
                    end else if (retry_q == RW'(RETRY_MAX)) begin
                        res_err_d = 1'b1;
                        res_d     = '0;
                        state_d   = FIN;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        state_d = WR_S;
                    end
                end
            end
            PL_S: state_d = PL_A;
            PL_A: begin
                if (bus.PREADY_i) begin
                    if (!bus.PSLVERR_i && ((bus.PRDATA_i & POLL_MASK) != 8'h00)) begin
                        state_d = RD_S;
                    end else if (poll_q == PW'(POLL_MAX - 1)) begin
                        res_err_d = 1'b1;
                        res_d     = '0;
                        state_d   = FIN;
                    end else begin
                        poll_d  = poll_q + 1'b1;
                        state_d = PL_S;
                    end
                end
            end
            RD_S: state_d = RD_A;
            RD_A: begin
                if (bus.PREADY_i) begin
                    res_d = bus.PRDATA_i;
                    if (bus.PSLVERR_i) res_err_d = 1'b1;
                    state_d = FIN;
                end
            end
            FIN: begin
                done_d  = NREQ'(1) << idx_q;
                rdata_d = res_q;
                err_d   = res_err_q;
                retry_d = '0;
                poll_d  = '0;
                state_d = ARB;
            end
`ifdef SPI_SEQ_INIT_EN
            INIT_S: state_d = INIT_A;
            INIT_A: begin
                if (bus.PREADY_i) begin
                    if (init_cnt_q == 2'd2) begin
                        init_done_d = 1'b1;
                        state_d     = ARB;
                    end else begin
                        init_cnt_d = init_cnt_q + 1'b1;
                        state_d    = INIT_S;
                    end
                end
            end
`endif
            default: state_d = ARB;
        endcase
        busy_d = (state_d != ARB);
    end

`ifdef SPI_SEQ_INIT_EN
    // Configuration byte for the current init register.
    always_comb begin
        case (init_cnt_d)
            2'd0:    init_byte_c = CR1_INIT;
            2'd1:    init_byte_c = CR2_INIT;
            default: init_byte_c = BR_INIT;
        endcase
    end
`endif

    // APB drive decoded from the next state so it lines up with the state register.
    always_comb begin
        apb_d = '0;
        case (state_d)
            WR_S, WR_A: begin
                apb_d.sel    = 1'b1;
                apb_d.enable = (state_d == WR_A);
                apb_d.write  = 1'b1;
                apb_d.addr   = ADDR_DR;
                apb_d.wdata  = byte_d;
            end
            PL_S, PL_A: begin
                apb_d.sel    = 1'b1;
                apb_d.enable = (state_d == PL_A);
                apb_d.addr   = ADDR_SR;
            end
            RD_S, RD_A: begin
                apb_d.sel    = 1'b1;
                apb_d.enable = (state_d == RD_A);
                apb_d.addr   = ADDR_DR;
            end
`ifdef SPI_SEQ_INIT_EN
            INIT_S, INIT_A: begin
                apb_d.sel    = 1'b1;
                apb_d.enable = (state_d == INIT_A);
                apb_d.write  = 1'b1;
                apb_d.addr   = ADDR_CR1 + {1'b0, init_cnt_d};
                apb_d.wdata  = init_byte_c;
            end
`endif
            default: apb_d = '0;
        endcase
    end

    assign bus.gnt_o     = gnt_q;
    assign bus.done_o    = done_q;
    assign bus.rdata_o   = rdata_q;
    assign bus.err_o     = err_q;
    assign bus.busy_o    = busy_q;
    assign bus.PSEL_o    = apb_q.sel;
    assign bus.PENABLE_o = apb_q.enable;
    assign bus.PWRITE_o  = apb_q.write;
    assign bus.PADDR_o   = apb_q.addr;
    assign bus.PWDATA_o  = apb_q.wdata;

endmodule

// File: tb/tb_spi_apb_xfer_sequencer.sv
// Bench for spi_apb_xfer_sequencer: randomized APB slave plus a
// transaction-level reference model of each transfer.
module tb_spi_apb_xfer_sequencer;

    localparam int unsigned NREQ      = 2;
    localparam int unsigned POLL_MAX  = 16;
    localparam int unsigned RETRY_MAX = 3;

    logic PCLK = 1'b0;
    logic PRESET = 1'b1;
    always #5 PCLK = ~PCLK;

    spi_apb_xfer_sequencer_if #(.NREQ(NREQ)) bus ();

    spi_apb_xfer_sequencer #(
        .NREQ(NREQ), .POLL_MASK(8'h80), .POLL_MAX(POLL_MAX), .RETRY_MAX(RETRY_MAX)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .bus(bus)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // slave configuration per transfer
    int         cfg_wr_err, cfg_sr_busy, cfg_sr_err, cfg_max_wait;
    logic [7:0] cfg_dr_val;
    logic       cfg_dr_err;

    // slave / monitor state
    int              wr_cnt, sr_cnt, wait_total, wc, wt;
    bit              in_acc;
    logic [11:0]     ops[$];
    logic [11:0]     exp_ops[$];
    int              cyc = 0, gnt_cnt = 0, done_cnt = 0, gnt_cyc = 0, done_cyc = 0;
    logic [NREQ-1:0] last_gnt, last_done;
    logic [7:0]      last_rdata;
    logic            last_err;
    logic [NREQ-1:0] gnt_hist[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge PCLK);
        #1;
    endtask

    // APB slave responder and output monitor
    always @(negedge PCLK) begin
        if (PRESET) begin
            in_acc        = 1'b0;
            bus.PREADY_i  = 1'b0;
            bus.PRDATA_i  = 8'h00;
            bus.PSLVERR_i = 1'b0;
        end else begin
            cyc++;
            if (bus.gnt_o != '0) begin
                gnt_cnt++;
                gnt_cyc    = cyc;
                last_gnt   = bus.gnt_o;
                gnt_hist.push_back(bus.gnt_o);
                wr_cnt     = 0;
                sr_cnt     = 0;
                wait_total = 0;
            end
            if (bus.done_o != '0) begin
                done_cnt++;
                done_cyc   = cyc;
                last_done  = bus.done_o;
                last_rdata = bus.rdata_o;
                last_err   = bus.err_o;
            end
            if (bus.PSEL_o && bus.PENABLE_o) begin
                if (!in_acc) begin
                    in_acc = 1'b1;
                    wc     = 0;
                    wt     = int'($urandom_range(0, cfg_max_wait));
                end
                if (wc < wt) begin
                    wc++;
                    wait_total++;
                    bus.PREADY_i  = 1'b0;
                    bus.PRDATA_i  = 8'($urandom);
                    bus.PSLVERR_i = 1'($urandom);
                end else begin
                    in_acc        = 1'b0;
                    bus.PREADY_i  = 1'b1;
                    bus.PSLVERR_i = 1'b0;
                    bus.PRDATA_i  = 8'($urandom);
                    ops.push_back({bus.PWRITE_o, bus.PADDR_o, bus.PWRITE_o ? bus.PWDATA_o : 8'h00});
                    if (bus.PWRITE_o) begin
                        if (bus.PADDR_o == 3'd5) begin
                            bus.PSLVERR_i = (wr_cnt < cfg_wr_err);
                            wr_cnt++;
                        end else begin
                            bus.PSLVERR_i = 1'($urandom);
                        end
                    end else if (bus.PADDR_o == 3'd3) begin
                        bus.PRDATA_i  = (sr_cnt >= cfg_sr_busy) ? (8'($urandom) | 8'h80)
                                                                : (8'($urandom) & 8'h7F);
                        bus.PSLVERR_i = (sr_cnt < cfg_sr_err);
                        sr_cnt++;
                    end else if (bus.PADDR_o == 3'd5) begin
                        bus.PRDATA_i  = cfg_dr_val;
                        bus.PSLVERR_i = cfg_dr_err;
                    end
                end
            end else begin
                in_acc        = 1'b0;
                bus.PREADY_i  = 1'($urandom);
                bus.PRDATA_i  = 8'($urandom);
                bus.PSLVERR_i = 1'($urandom);
            end
        end
    end

    // Reference: expected APB operation list and result of one transfer.
    task automatic model(input logic [7:0] b, output logic [7:0] rd, output logic er);
        int writes, first_done, polls;
        bit fail;
        fail = 1'b0;
        exp_ops.delete();
        if (cfg_wr_err > int'(RETRY_MAX)) begin
            writes = RETRY_MAX + 1;
            fail   = 1'b1;
        end else begin
            writes = cfg_wr_err + 1;
        end
        repeat (writes) exp_ops.push_back({1'b1, 3'd5, b});
        if (!fail) begin
            first_done = (cfg_sr_busy > cfg_sr_err) ? cfg_sr_busy : cfg_sr_err;
            fail  = (first_done >= int'(POLL_MAX));
            polls = fail ? POLL_MAX : first_done + 1;
            repeat (polls) exp_ops.push_back({1'b0, 3'd3, 8'h00});
        end
        if (!fail) begin
            exp_ops.push_back({1'b0, 3'd5, 8'h00});
            rd = cfg_dr_val;
            er = cfg_dr_err;
        end else begin
            rd = 8'h00;
            er = 1'b1;
        end
    endtask

    task automatic run_xfer(input string tag, input int r, input logic [7:0] b);
        logic [7:0] erd;
        logic       er;
        int         g0, d0;
        bit         ok;
        model(b, erd, er);
        ops.delete();
        g0 = gnt_cnt;
        d0 = done_cnt;
        bus.wdata_i[8*r +: 8] = b;
        bus.req_i[r] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            tick();
            ok = (gnt_cnt > g0);
        end
        chk({tag, "_gnt_seen"}, 32'(ok), 32'd1);
        chk({tag, "_gnt"}, 32'(last_gnt), 32'd1 << r);
        chk({tag, "_busy"}, 32'(bus.busy_o), 32'd1);
        bus.req_i[r] = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            tick();
            ok = (done_cnt > d0);
        end
        chk({tag, "_done_seen"}, 32'(ok), 32'd1);
        chk({tag, "_done"}, 32'(last_done), 32'd1 << r);
        chk({tag, "_rdata"}, 32'(last_rdata), 32'(erd));
        chk({tag, "_err"}, 32'(last_err), 32'(er));
        chk({tag, "_latency"}, 32'(done_cyc - gnt_cyc), 32'(2 * exp_ops.size() + wait_total + 1));
        chk({tag, "_nops"}, 32'(ops.size()), 32'(exp_ops.size()));
        for (int i = 0; i < exp_ops.size(); i++)
            chk({tag, "_op"}, (i < ops.size()) ? 32'(ops[i]) : 32'hFFFF_FFFF, 32'(exp_ops[i]));
    endtask

    task automatic set_cfg(input int we, input int sb, input int se, input logic [7:0] dv,
                           input logic de, input int mw);
        cfg_wr_err = we; cfg_sr_busy = sb; cfg_sr_err = se;
        cfg_dr_val = dv; cfg_dr_err = de; cfg_max_wait = mw;
    endtask

    task automatic post_reset();
`ifdef SPI_SEQ_INIT_EN
        int g0;
        g0 = gnt_cnt;
        for (int i = 0; i < 100 && (ops.size() < 3 || bus.busy_o); i++) tick();
        chk("init_nops", 32'(ops.size()), 32'd3);
        chk("init_cr1", (ops.size() > 0) ? 32'(ops[0]) : 32'hFFFF_FFFF, 32'h854);
        chk("init_cr2", (ops.size() > 1) ? 32'(ops[1]) : 32'hFFFF_FFFF, 32'h900);
        chk("init_br",  (ops.size() > 2) ? 32'(ops[2]) : 32'hFFFF_FFFF, 32'hA00);
        chk("init_no_gnt", 32'(gnt_cnt), 32'(g0));
`endif
        ops.delete();
    endtask

    initial begin
        int         g0, d0, r;
        bit         ok;
        logic [7:0] b;
        bus.req_i   = '0;
        bus.wdata_i = '0;
        set_cfg(0, 0, 0, 8'h00, 1'b0, 0);
        repeat (3) tick();
        chk("reset_outputs", 32'({bus.gnt_o, bus.done_o, bus.rdata_o, bus.err_o, bus.busy_o,
                                  bus.PSEL_o, bus.PENABLE_o, bus.PWRITE_o, bus.PADDR_o,
                                  bus.PWDATA_o}), 32'd0);
        PRESET = 1'b0;
        tick();
        chk("post_reset_idle", 32'({bus.gnt_o, bus.done_o, bus.PSEL_o}), 32'd0);
        post_reset();

        // first-poll success, zero wait
        set_cfg(0, 0, 0, 8'h3C, 1'b0, 0);
        run_xfer("basic", 0, 8'hA5);
        chk("basic_lat7", 32'(done_cyc - gnt_cyc), 32'd7);
        // three busy polls
        set_cfg(0, 3, 0, 8'($urandom), 1'b0, 2);
        run_xfer("poll4", 1, 8'($urandom));
        // poll timeout
        set_cfg(0, 99, 0, 8'h77, 1'b0, 1);
        run_xfer("poll_tmo", 0, 8'($urandom));
        // DR write always errors
        set_cfg(99, 0, 0, 8'h55, 1'b0, 1);
        run_xfer("wr_fail", 1, 8'($urandom));
        // single write retry
        set_cfg(1, 0, 0, 8'h9E, 1'b0, 0);
        run_xfer("wr_retry1", 0, 8'h12);
        // SR slave error with SPIF set, DR read error
        set_cfg(0, 0, 2, 8'hC3, 1'b1, 2);
        run_xfer("sr_err", 1, 8'h81);

        // randomized transfers
        for (int n = 0; n < 8; n++) begin
            r = int'($urandom_range(0, NREQ - 1));
            b = 8'($urandom);
            set_cfg(int'($urandom_range(0, 4)),
                    ($urandom_range(0, 5) == 0) ? 20 : int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 2)), 8'($urandom),
                    ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)));
            run_xfer("rand", r, b);
        end

        // reset during SR poll access phase
        set_cfg(0, 99, 0, 8'h00, 1'b0, 2);
        g0 = gnt_cnt;
        bus.req_i[0] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            tick();
            ok = (gnt_cnt > g0);
        end
        bus.req_i[0] = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            tick();
            ok = bus.PSEL_o && bus.PENABLE_o && (bus.PADDR_o == 3'd3);
        end
        chk("rst_reach_pl_a", 32'(ok), 32'd1);
        d0 = done_cnt;
        #2 PRESET = 1'b1;
        #1;
        chk("rst_psel_penable", 32'({bus.PSEL_o, bus.PENABLE_o}), 32'd0);
        repeat (3) tick();
        PRESET = 1'b0;
        post_reset();
        repeat (20) tick();
        chk("rst_no_done", 32'(done_cnt), 32'(d0));
        chk("rst_idle", 32'(bus.busy_o), 32'd0);

        // round robin with both requesters held
        set_cfg(0, 0, 0, 8'h6B, 1'b0, 1);
        gnt_hist.delete();
        g0 = gnt_cnt;
        d0 = done_cnt;
        bus.wdata_i = 16'h2211;
        bus.req_i   = 2'b11;
        for (int i = 0; i < 200 && gnt_cnt < g0 + 3; i++) tick();
        bus.req_i = 2'b00;
        for (int i = 0; i < 200 && done_cnt < d0 + 3; i++) tick();
        chk("rr_done_cnt", 32'(done_cnt - d0), 32'd3);
        for (int i = 0; i < 3; i++)
            chk("rr_gnt", (i < gnt_hist.size()) ? 32'(gnt_hist[i]) : 32'hFF, 32'd1 << (i % 2));
        repeat (5) tick();
        chk("rr_hold_rdata", 32'(bus.rdata_o), 32'h6B);
        chk("rr_no_extra_gnt", 32'(gnt_cnt - g0), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
